// File: rtl/ascon_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ascon_round_ctrl
// Brief    : Round sequencer for the Ascon permutation (p^a / p^b) datapath.
// Revision : 1.0 - initial release
// ============================================================================
module ascon_round_ctrl #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       ena_reg_state_o,
  output logic       sel_init_o,
  output logic [3:0] round_o
);

  // p^N uses the last N round constants, so the index starts at 12 - N.
  localparam logic [3:0] c_first_a = 4'(12 - ROUNDS_A);
  localparam logic [3:0] c_first_b = 4'(12 - ROUNDS_B);
  localparam logic [3:0] c_last    = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_mode;
  logic [3:0] r_count;

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state         <= S_IDLE;
      r_mode          <= 1'b0;
      r_count         <= 4'd0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      ena_reg_state_o <= 1'b0;
      sel_init_o      <= 1'b0;
      round_o         <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state         <= S_LOAD;
            r_mode          <= mode_i;
            busy_o          <= 1'b1;
            ena_reg_state_o <= 1'b1;
            sel_init_o      <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state    <= S_ROUND;
          r_count    <= r_mode ? c_first_b : c_first_a;
          round_o    <= r_mode ? c_first_b : c_first_a;
          sel_init_o <= 1'b0;
        end
        S_ROUND: begin
          if (r_count == c_last) begin
            r_state         <= S_DONE;
            busy_o          <= 1'b0;
            ena_reg_state_o <= 1'b0;
            done_o          <= 1'b1;
          end else begin
            r_count <= r_count + 4'd1;
            round_o <= r_count + 4'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_count <= 4'd0;
          done_o  <= 1'b0;
          round_o <= 4'd0;
        end
        default: begin
          r_state         <= S_IDLE;
          r_count         <= 4'd0;
          busy_o          <= 1'b0;
          done_o          <= 1'b0;
          ena_reg_state_o <= 1'b0;
          sel_init_o      <= 1'b0;
          round_o         <= 4'd0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ascon_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_round_ctrl
// Brief    : Scoreboard bench for ascon_round_ctrl (default and ROUNDS_A=8).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ascon_round_ctrl;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic       start8  = 1'b0;
  logic       mode_i  = 1'b0;

  logic       busy_a, done_a, ena_a, sel_a;
  logic [3:0] round_a;
  logic       busy_b, done_b, ena_b, sel_b;
  logic [3:0] round_b;

  ascon_round_ctrl dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i),
    .busy_o(busy_a), .done_o(done_a), .ena_reg_state_o(ena_a),
    .sel_init_o(sel_a), .round_o(round_a)
  );

  ascon_round_ctrl #(.ROUNDS_A(8), .ROUNDS_B(6)) dut8 (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start8), .mode_i(mode_i),
    .busy_o(busy_b), .done_o(done_b), .ena_reg_state_o(ena_b),
    .sel_init_o(sel_b), .round_o(round_b)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] v;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   end_req  = 1'b0;
  bit   mon_done = 1'b0;

  // Packed view: {busy, done, ena, sel, round[3:0]}
  function automatic logic [7:0] pk(bit b, bit d, bit e, bit s, int r);
    return {b, d, e, s, 4'(r)};
  endfunction

  task automatic push_one(input bit to8, input int c, input logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    if (to8) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  // Expected trace of one permutation started (start sampled) at cycle s.
  task automatic push_run(input int s, input int n, input int limit, input bit to8);
    if (s + 1 <= limit) push_one(to8, s + 1, pk(1, 0, 1, 1, 0));
    for (int k = 0; k < n; k++)
      if (s + 2 + k <= limit) push_one(to8, s + 2 + k, pk(1, 0, 1, 0, 12 - n + k));
    if (s + n + 2 <= limit) push_one(to8, s + n + 2, pk(0, 1, 0, 0, 11));
  endtask

  task automatic cmp(input string nm, input int c, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got {busy,done,ena,sel,round}=%b required %b", nm, c, act, exp);
    end
  endtask

  task automatic proc(input bit sel, input logic [7:0] obs, input string nm);
    exp_t head;
    bit   have;
    have = 1'b0;
    while (1) begin
      have = sel ? (q_b.size() > 0) : (q_a.size() > 0);
      if (!have) break;
      head = sel ? q_b[0] : q_a[0];
      if (head.cyc >= cyc) break;
      n_checks++;
      n_errors++;
      $display("FAIL %s missing output for cycle %0d: got nothing required %b", nm, head.cyc, head.v);
      if (sel) void'(q_b.pop_front());
      else     void'(q_a.pop_front());
    end
    if (have && head.cyc == cyc) begin
      cmp(nm, cyc, obs, head.v);
      if (sel) void'(q_b.pop_front());
      else     void'(q_a.pop_front());
    end else if (obs != 8'd0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s unexpected output cycle %0d: got %b required 00000000", nm, cyc, obs);
    end
  endtask

  // Monitor: matches DUT activity against the expectation queues.
  initial begin
    while (!mon_done) begin
      @(negedge clock_i);
      proc(1'b0, {busy_a, done_a, ena_a, sel_a, round_a}, "dut_a");
      proc(1'b1, {busy_b, done_b, ena_b, sel_b, round_b}, "dut_a8");
      #3;
      if (reset_i) begin
        cmp("reset_clear_a", cyc, {busy_a, done_a, ena_a, sel_a, round_a}, 8'd0);
        cmp("reset_clear_a8", cyc, {busy_b, done_b, ena_b, sel_b, round_b}, 8'd0);
      end
      if (end_req) begin
        cmp("queue_a_empty", cyc, 8'(q_a.size()), 8'd0);
        cmp("queue_a8_empty", cyc, 8'(q_b.size()), 8'd0);
        mon_done = 1'b1;
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q_a.size() == 0 && q_b.size() == 0) break;
      @(negedge clock_i);
    end
    repeat (3) @(negedge clock_i);
  endtask

  task automatic go(input bit m, input bit on8);
    int s;
    s = cyc;
    mode_i = m;
    if (on8) begin
      start8 = 1'b1;
      push_run(s, m ? 6 : 8, 1 << 30, 1'b1);
    end else begin
      start_i = 1'b1;
      push_run(s, m ? 6 : 12, 1 << 30, 1'b0);
    end
    @(negedge clock_i);
    start_i = 1'b0;
    start8  = 1'b0;
    drain();
  endtask

  initial begin
    int s;
    // Reset held with start toggling, then released with no start: all zero.
    for (int c = 1; c <= 7; c++) begin
      push_one(1'b0, c, 8'd0);
      push_one(1'b1, c, 8'd0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_i);
      start_i = ~start_i;
      start8  = ~start8;
    end
    start_i = 1'b0;
    start8  = 1'b0;
    reset_i = 1'b0;
    repeat (3) @(negedge clock_i);

    go(1'b0, 1'b0);   // p^a, 12 rounds
    go(1'b1, 1'b0);   // p^b, 6 rounds

    // start held high through a p^b run, mode flipped to 0 afterwards
    s = cyc;
    start_i = 1'b1;
    mode_i  = 1'b1;
    push_run(s, 6, 1 << 30, 1'b0);
    @(negedge clock_i);
    mode_i = 1'b0;
    repeat (8) @(negedge clock_i);
    push_run(s + 9, 12, 1 << 30, 1'b0);
    @(negedge clock_i);
    start_i = 1'b0;
    drain();

    // Asynchronous reset pulse while round_o=3 of a p^a run
    s = cyc;
    start_i = 1'b1;
    mode_i  = 1'b0;
    push_run(s, 12, s + 5, 1'b0);
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (4) @(negedge clock_i);
    #1 reset_i = 1'b1;
    #3 reset_i = 1'b0;
    repeat (4) @(negedge clock_i);
    go(1'b0, 1'b0);

    go(1'b0, 1'b1);   // ROUNDS_A=8 instance
    go(1'b1, 1'b1);

    end_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (mon_done) break;
      @(negedge clock_i);
    end
    #4;
    if (!mon_done) begin
      $display("FAIL monitor_finish: got not finished required finished");
      n_errors++;
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
